// File: rtl/sync_up_counter_4bit.sv
// Synchronous up counter with enable, clear, parallel load, programmable terminal
// value and cascade carry; q, wrap and ovf are registered, tc and cout are combinational.
module sync_up_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             cin,
  input  logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             ovf_r;
  logic             ovf_next_s;
  logic             adv_s;
  logic             tc_s;
  logic             wrap_hit_s;

  assign adv_s      = en & cin;
  assign tc_s       = (q_r == top);
  // All-ones is only reachable above top (loaded or top lowered live): natural wrap.
  assign wrap_hit_s = adv_s & (tc_s | (q_r == ONES));

  // Next-state selection in synchronous priority order: clr, load, wrap, count, hold.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    ovf_next_s  = ovf_r;
    if (clr) begin
      q_next_s    = ZERO;
      wrap_next_s = 1'b0;
      ovf_next_s  = 1'b0;
    end else if (load) begin
      q_next_s    = d;
      wrap_next_s = 1'b0;
    end else if (wrap_hit_s) begin
      q_next_s    = ZERO;
      wrap_next_s = 1'b1;
      ovf_next_s  = 1'b1;
    end else if (adv_s) begin
      q_next_s    = q_r + ONE;
      wrap_next_s = 1'b0;
    end else begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
    end
  end

  // Count, wrap-pulse and sticky-overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= ZERO;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
      ovf_r  <= ovf_next_s;
    end
  end

  assign q    = q_r;
  assign tc   = tc_s;
  assign cout = tc_s & adv_s;
  assign wrap = wrap_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_sync_up_counter_4bit.sv
// Directed, table-driven bench for sync_up_counter_4bit plus hand-written
// sequences for async reset mid-count and an 8-bit two-stage cascade.
module tb_sync_up_counter_4bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, load, en, cin;
  logic [3:0] d, top, q;
  logic       tc, cout, wrap, ovf;

  logic       c_clr, c_load, c_en;
  logic [3:0] c_d, c_top;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_cout, lo_wrap, lo_ovf;
  logic       hi_tc, hi_cout, hi_wrap, hi_ovf;

  sync_up_counter_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .cin(cin),
    .top(top), .q(q), .tc(tc), .cout(cout), .wrap(wrap), .ovf(ovf)
  );

  sync_up_counter_4bit #(.WIDTH(4)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .d(c_d), .en(c_en), .cin(1'b1),
    .top(c_top), .q(lo_q), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap), .ovf(lo_ovf)
  );

  sync_up_counter_4bit #(.WIDTH(4)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .d(c_d), .en(c_en), .cin(lo_cout),
    .top(c_top), .q(hi_q), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap), .ovf(hi_ovf)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic       en;
    logic       cin;
    logic [3:0] top;
    logic [3:0] q;
    logic       tc;
    logic       cout;
    logic       wrap;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic c, input logic l, input logic [3:0] dd,
                               input logic e, input logic ci, input logic [3:0] t,
                               input logic [3:0] qq, input logic etc, input logic eco,
                               input logic ew, input logic eo);
    vec_t r;
    r.clr = c;  r.load = l; r.d = dd; r.en = e; r.cin = ci; r.top = t;
    r.q = qq;   r.tc = etc; r.cout = eco; r.wrap = ew; r.ovf = eo;
    return r;
  endfunction

  // Advancing step (en=cin=1, no clr/load): cout equals tc.
  function automatic void cnt(input logic [3:0] t, input logic [3:0] qq,
                              input logic etc, input logic ew, input logic eo);
    vecs.push_back(mkv(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, t, qq, etc, etc, ew, eo));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp8;

    rst_n = 1'b0; clr = 1'b0; load = 1'b0; d = 4'd0; en = 1'b1; cin = 1'b1; top = 4'd0;
    c_clr = 1'b0; c_load = 1'b0; c_d = 4'd0; c_top = 4'd15; c_en = 1'b0;

    #3;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tc_top0", 32'(tc), 32'd1);
    chk("rst_cout_top0", 32'(cout), 32'd1);
    top = 4'd15; en = 1'b0;
    #1;
    chk("rst_tc_top15", 32'(tc), 32'd0);
    chk("rst_cout_top15", 32'(cout), 32'd0);

    // Reset and count through full mod-16 wrap.
    for (int i = 1; i <= 15; i++) cnt(4'd15, i[3:0], (i == 15), 1'b0, 1'b0);
    cnt(4'd15, 4'd0, 1'b0, 1'b1, 1'b1);
    cnt(4'd15, 4'd1, 1'b0, 1'b0, 1'b1);
    // Hold at 5, load beats count, clr beats load.
    for (int i = 2; i <= 5; i++) cnt(4'd15, i[3:0], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Modulus 10, then top lowered to 3 while q=7.
    for (int i = 1; i <= 9; i++) cnt(4'd9, i[3:0], (i == 9), 1'b0, 1'b0);
    cnt(4'd9, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) cnt(4'd9, i[3:0], 1'b0, 1'b0, 1'b1);
    for (int i = 8; i <= 15; i++) cnt(4'd3, i[3:0], 1'b0, 1'b0, 1'b1);
    cnt(4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) cnt(4'd3, i[3:0], (i == 3), 1'b0, 1'b1);
    cnt(4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
    // top=0: wrap every cycle; then hold; then load 12 above top=5.
    for (int i = 0; i < 3; i++) cnt(4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    vecs.push_back(mkv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 4'd5, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 13; i <= 15; i++) cnt(4'd5, i[3:0], 1'b0, 1'b0, 1'b1);
    cnt(4'd5, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) cnt(4'd5, i[3:0], (i == 5), 1'b0, 1'b1);
    cnt(4'd5, 4'd0, 1'b0, 1'b1, 1'b1);
    // cin=0 blocks advance.
    for (int i = 0; i < 2; i++)
      vecs.push_back(mkv(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Set up q=11 for the async reset sequence.
    vecs.push_back(mkv(1'b0, 1'b1, 4'd10, 1'b1, 1'b1, 4'd15, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1));
    cnt(4'd15, 4'd11, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; load = vecs[i].load; d = vecs[i].d;
      en = vecs[i].en; cin = vecs[i].cin; top = vecs[i].top;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].wrap));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end

    // Async reset between edges while q=11 (en still high).
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_q", 32'(q), 32'd0);
    chk("arst_hold_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arst_release_q", 32'(q), 32'd1);
    chk("arst_release_ovf", 32'(ovf), 32'd0);

    // 8-bit cascade: 0x00 -> 0xFF -> 0x00.
    c_en = 1'b1;
    exp8 = 8'h00;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp8 = exp8 + 8'h01;
      chk($sformatf("casc_%0d", k), 32'({hi_q, lo_q}), 32'(exp8));
      if (k == 255) chk("casc_hi_cout_ff", 32'(hi_cout), 32'd1);
      if (k == 256) begin
        chk("casc_hi_wrap", 32'(hi_wrap), 32'd1);
        chk("casc_hi_ovf", 32'(hi_ovf), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
